hazard_ctrl_d: RTL and testbench
================================

// Module: hazard_ctrl_d
// PURPOSE
//  Hazard/forwarding controller for the D stage of the 5-stage pipeline.
//  Keeps shadow E and M records {A3, Tnew, md_start}, one per in-flight instruction.
//  Drives the 2-bit select of the D-stage compare/forward muxes for rs and rt:
//  10 = E_out, 01 = M_out, 00 = GRF read. Also raises the D-stage stall.
//  Tracks mult/div busy so HI/LO users stall while the multiply/divide unit is running.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles loaded for mult/multu
//  DIV_CYCLES   10  busy cycles loaded for div/divu
//  CNT_W        4   width of the busy counter; must satisfy 2**CNT_W > DIV_CYCLES
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high; clears all state
//  D_rs         in   5  rs index of the instruction in D
//  D_rt         in   5  rt index of the instruction in D
//  D_Tuse_rs    in   2  cycles until rs is consumed (0..2); 3 = rs unused
//  D_Tuse_rt    in   2  same for rt
//  D_A3         in   5  destination register of the D instruction; 0 = none
//  D_Tnew       in   2  cycles after entering E until the result exists (0..2)
//  D_md_start   in   1  D instruction is mult/multu/div/divu
//  D_md_is_div  in   1  with D_md_start: 1 = div, 0 = mult
//  D_md_use     in   1  D instruction touches HI/LO (mf*, mt*, or a md start)
//  FW_sel_rs    out  2  forward select for rs: 10 = E, 01 = M, 00 = GRF
//  FW_sel_rt    out  2  forward select for rt, same encoding
//  stall        out  1  1 = hold PC and the D register, and bubble E
//  md_busy      out  1  1 = multiply/divide unit is occupied
// BEHAVIOUR
//  Reset:
//   - async reset clears E, M and the counter; A3=0, Tnew=0, md_start=0, cnt=0.
//   - While in reset, all outputs are 0.
//  Record update, each posedge:
//   - Normal advance: E <= {D_A3, D_Tnew, D_md_start, D_md_is_div}; M <= {E.A3, sat_dec(E.Tnew), 0}.
//   - When stall=1: E <= bubble (all fields 0); M still advances from E.
//   - sat_dec(x) = (x==0) ? 0 : x-1. Tnew never wraps.
//  Stage match (per source s in {rs, rt}):
//   - hitE = (E.A3 == D_s) && (D_s != 0).
//   - hitM = (M.A3 == D_s) && (D_s != 0).
//  Forward select (combinational, E has priority):
//   - hitE && E.Tnew==0                 -> 10
//   - else hitM && M.Tnew==0            -> 01
//   - else                              -> 00
//   - The W stage is never forwarded here; the GRF write-through covers it.
//  Data stall:
//   - stall_s = (hitE && E.Tnew > Tuse_s) || (!hitE && hitM && M.Tnew > Tuse_s).
//   - Tuse 3 never stalls.
//   - If hitE with E.Tnew <= Tuse but E.Tnew != 0: no stall, select 00. The operand is re-read later.
//  Mult/div busy:
//   - md_busy = E.md_start || (cnt != 0).
//   - On the edge where E.md_start=1 leaves E: cnt <= E.md_is_div ? DIV_CYCLES : MULT_CYCLES.
//   - Otherwise, if cnt != 0: cnt <= cnt - 1.
//   - md_stall = D_md_use && md_busy.
//  stall = stall_rs || stall_rt || md_stall. Zero-cycle latency: a pure function of the current D inputs and state.
//  Boundary cases:
//   - A3 = 0 never matches.
//   - A md start in E is not lost while stall=1; M advances and the counter loads.
//   - A back-to-back md start is impossible, because the second one stalls on md_busy.
//   - Reset mid-count drops busy immediately.
// STRUCTURE
//  Shared package pipe_pkg:
//   - FW_GRF=2'b00, FW_M=2'b01, FW_E=2'b10
//   - TUSE_NONE=2'd3
//   - stage record struct {A3, Tnew, md_start, md_is_div}
//  Sub-module md_busy_cnt:
//   - holds the counter, load mux and md_busy.
//   - hazard_ctrl_d keeps the records, match logic and stall OR.
// TESTING
//  1. add $1 in E (Tnew 1 -> E.Tnew=1), then beq $1 in D (Tuse 0) -> stall=1 for 1 cycle; next cycle FW_sel_rs=01.
//  2. lw $2 then beq $2 -> stall 2 cycles (E.Tnew=2, then M.Tnew=1); third cycle FW_sel=00, stall=0.
//  3. jal/lui with D_Tnew=0 writing $31, then jr $31 -> FW_sel_rs=10, no stall. With D_rs=0 and E.A3=0 -> FW_sel 00.
//  4. $3 written in both E and M, E.Tnew=0 -> E wins, FW_sel=10.
//  5. div leaves E, mfhi in D -> stall high for 11 cycles (E + 10 counted); mult instead -> 6 cycles.
//  6. reset asserted mid-div with cnt=7 -> md_busy and stall drop to 0 without a clock; all records are bubbles afterwards.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the D-stage hazard controller.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned TN_W  = 2;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] FW_GRF    = 2'b00;
    localparam logic [SEL_W-1:0] FW_M      = 2'b01;
    localparam logic [SEL_W-1:0] FW_E      = 2'b10;
    localparam logic [TN_W-1:0]  TUSE_NONE = 2'd3;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic [REG_W-1:0] a3;
        logic [TN_W-1:0]  tnew;
        logic             md_start;
        logic             md_is_div;
    } stage_rec_t;

    localparam stage_rec_t STAGE_BUBBLE = '0;

    // Saturating decrement: Tnew counts down to zero and stays there.
    function automatic logic [TN_W-1:0] sat_dec(input logic [TN_W-1:0] x);
        return (x == '0) ? '0 : x - TN_W'(1);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy tracker: loads a cycle count when a md start leaves E.
module md_busy_cnt #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on a departing md start, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register; reset drops busy immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Busy covers the cycle the start sits in E plus the counted cycles.
    assign busy_o = start_i || (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_d.sv
// D-stage hazard/forwarding controller: shadow E/M records, forward selects, stall.
module hazard_ctrl_d
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] D_rs,
    input  logic [REG_W-1:0] D_rt,
    input  logic [TN_W-1:0]  D_Tuse_rs,
    input  logic [TN_W-1:0]  D_Tuse_rt,
    input  logic [REG_W-1:0] D_A3,
    input  logic [TN_W-1:0]  D_Tnew,
    input  logic             D_md_start,
    input  logic             D_md_is_div,
    input  logic             D_md_use,
    output logic [SEL_W-1:0] FW_sel_rs,
    output logic [SEL_W-1:0] FW_sel_rt,
    output logic             stall,
    output logic             md_busy
);

    stage_rec_t e_q;
    stage_rec_t e_d;
    stage_rec_t m_q;
    stage_rec_t m_d;

    logic stall_rs;
    logic stall_rt;
    logic md_stall;

    // Per-source decision, returned as {stall, select}; E outranks M.
    function automatic logic [SEL_W:0] src_ctrl(
        input logic [REG_W-1:0] src,
        input logic [TN_W-1:0]  tuse,
        input stage_rec_t       e,
        input stage_rec_t       m
    );
        logic             hit_e;
        logic             hit_m;
        logic             stl;
        logic [SEL_W-1:0] sel;
        hit_e = (e.a3 == src) && (src != '0);
        hit_m = (m.a3 == src) && (src != '0);
        stl   = 1'b0;
        sel   = FW_GRF;
        if (tuse != TUSE_NONE) begin
            stl = (hit_e && (e.tnew > tuse)) || (!hit_e && hit_m && (m.tnew > tuse));
        end
        if (hit_e && (e.tnew == '0)) begin
            sel = FW_E;
        end else if (hit_m && (m.tnew == '0)) begin
            sel = FW_M;
        end
        return {stl, sel};
    endfunction

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .start_i  (e_q.md_start),
        .is_div_i (e_q.md_is_div),
        .busy_o   (md_busy)
    );

    // Forward selects and the combined stall, purely from D inputs and records.
    always_comb begin
        {stall_rs, FW_sel_rs} = src_ctrl(D_rs, D_Tuse_rs, e_q, m_q);
        {stall_rt, FW_sel_rt} = src_ctrl(D_rt, D_Tuse_rt, e_q, m_q);
        md_stall = D_md_use && md_busy;
        stall    = stall_rs || stall_rt || md_stall;
    end

    // Next records: E takes D or a bubble on stall, M always advances from E.
    always_comb begin
        e_d = STAGE_BUBBLE;
        if (!stall) begin
            e_d.a3        = D_A3;
            e_d.tnew      = D_Tnew;
            e_d.md_start  = D_md_start;
            e_d.md_is_div = D_md_is_div;
        end
        m_d      = STAGE_BUBBLE;
        m_d.a3   = e_q.a3;
        m_d.tnew = sat_dec(e_q.tnew);
    end

    // Record registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= STAGE_BUBBLE;
            m_q <= STAGE_BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_d.sv
// Self-checking bench for hazard_ctrl_d: directed pipeline scenarios plus random traffic.
module tb_hazard_ctrl_d;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       D_md_start, D_md_is_div, D_md_use;
    logic [1:0] FW_sel_rs, FW_sel_rt;
    logic       stall, md_busy;

    int total = 0;
    int bad   = 0;

    // Reference model: producers carry the absolute cycle their result exists;
    // the md unit is occupied until an absolute deadline cycle.
    int         now;
    logic [4:0] e_a3, m_a3;
    int         e_ready, m_ready;
    logic       e_md, e_div;
    int         busy_until;

    logic       last_stall;
    logic [1:0] last_fw_rs;

    always #5 clk = ~clk;

    hazard_ctrl_d dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_Tuse_rs   (D_Tuse_rs),
        .D_Tuse_rt   (D_Tuse_rt),
        .D_A3        (D_A3),
        .D_Tnew      (D_Tnew),
        .D_md_start  (D_md_start),
        .D_md_is_div (D_md_is_div),
        .D_md_use    (D_md_use),
        .FW_sel_rs   (FW_sel_rs),
        .FW_sel_rt   (FW_sel_rt),
        .stall       (stall),
        .md_busy     (md_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rem(input int rdy);
        return (rdy > now) ? rdy - now : 0;
    endfunction

    // Expected {stall, select} for one source operand.
    function automatic logic [2:0] exp_src(input logic [4:0] s, input logic [1:0] tuse);
        logic       he, hm, st;
        int         re, rm;
        logic [1:0] sel;
        he  = (s != 5'd0) && (s == e_a3);
        hm  = (s != 5'd0) && (s == m_a3);
        re  = rem(e_ready);
        rm  = rem(m_ready);
        st  = (he && re > int'(tuse)) || (!he && hm && rm > int'(tuse));
        sel = 2'b00;
        if (he && re == 0)      sel = 2'b10;
        else if (hm && rm == 0) sel = 2'b01;
        return {st, sel};
    endfunction

    task automatic model_reset();
        e_a3 = '0; m_a3 = '0; e_ready = 0; m_ready = 0;
        e_md = 1'b0; e_div = 1'b0; busy_until = -1;
    endtask

    task automatic drv(input logic [4:0] rs, input logic [1:0] tur, input logic [4:0] rt,
                       input logic [1:0] tut, input logic [4:0] a3, input logic [1:0] tn,
                       input logic ms, input logic dv, input logic mu);
        D_rs = rs; D_Tuse_rs = tur; D_rt = rt; D_Tuse_rt = tut;
        D_A3 = a3; D_Tnew = tn; D_md_start = ms; D_md_is_div = dv; D_md_use = mu;
    endtask

    task automatic nop();
        drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic step();
        logic [2:0] xr, xt;
        logic       xb, xs;
        xr = exp_src(D_rs, D_Tuse_rs);
        xt = exp_src(D_rt, D_Tuse_rt);
        xb = e_md || (now <= busy_until);
        xs = xr[2] || xt[2] || (D_md_use && xb);
        @(negedge clk);
        chk("fw_rs", 32'(FW_sel_rs), 32'(xr[1:0]));
        chk("fw_rt", 32'(FW_sel_rt), 32'(xt[1:0]));
        chk("md_busy", 32'(md_busy), 32'(xb));
        chk("stall", 32'(stall), 32'(xs));
        last_stall = stall;
        last_fw_rs = FW_sel_rs;
        @(posedge clk);
        if (e_md) busy_until = now + (e_div ? 10 : 5);
        m_a3 = e_a3; m_ready = e_ready;
        if (xs) begin
            e_a3 = '0; e_ready = 0; e_md = 1'b0; e_div = 1'b0;
        end else begin
            e_a3 = D_A3; e_ready = now + 1 + int'(D_Tnew); e_md = D_md_start; e_div = D_md_is_div;
        end
        now++;
        #1;
    endtask

    // Asynchronous reset in mid-cycle: outputs must drop without a clock edge.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_fw_rs"}, 32'(FW_sel_rs), 32'd0);
        chk({tag, "_fw_rt"}, 32'(FW_sel_rt), 32'd0);
        chk({tag, "_busy"}, 32'(md_busy), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        model_reset();
        @(posedge clk);
        now++;
        #1;
        reset = 1'b0;
    endtask

    task automatic flush();
        nop();
        repeat (3) step();
    endtask

    // Hold an HI/LO user in D behind a md start and measure the stall length.
    task automatic md_len(input logic is_div, input int exp_len, input string tag);
        int n;
        flush();
        drv(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1, is_div, 1'b1);
        step();
        drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd0, 1'b0, 1'b0, 1'b1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!last_stall) break;
            n++;
        end
        chk(tag, 32'(n), 32'(exp_len));
    endtask

    initial begin
        now = 0;
        model_reset();
        last_stall = 1'b0;
        last_fw_rs = '0;
        reset = 1'b1;
        drv(5'd1, 2'd0, 5'd2, 2'd0, 5'd1, 2'd2, 1'b1, 1'b1, 1'b1);
        #2;
        chk("rst0_busy", 32'(md_busy), 32'd0);
        chk("rst0_stall", 32'(stall), 32'd0);
        chk("rst0_fw_rs", 32'(FW_sel_rs), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ALU producer with Tnew 1, branch consumer with Tuse 0.
        flush();
        drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        drv(5'd1, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("t1_stall", 32'(last_stall), 32'd1);
        step();
        chk("t1_stall_end", 32'(last_stall), 32'd0);
        chk("t1_fw_m", 32'(last_fw_rs), 32'd1);

        // Load producer with Tnew 2, branch consumer: two stall cycles.
        flush();
        drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drv(5'd2, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("t2_stall1", 32'(last_stall), 32'd1);
        step();
        chk("t2_stall2", 32'(last_stall), 32'd1);
        step();
        chk("t2_stall3", 32'(last_stall), 32'd0);
        chk("t2_fw_grf", 32'(last_fw_rs), 32'd0);

        // Link write to $31 with Tnew 0, then jr $31; then $0 never matches.
        flush();
        drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drv(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("t3_fw_e", 32'(last_fw_rs), 32'd2);
        chk("t3_nostall", 32'(last_stall), 32'd0);
        drv(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("t3_zero_fw", 32'(last_fw_rs), 32'd0);

        // $3 written in both E and M with Tnew 0: E wins.
        flush();
        drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        drv(5'd3, 2'd0, 5'd3, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("t4_fw_e", 32'(last_fw_rs), 32'd2);

        // Divide and multiply busy windows seen by an HI/LO reader.
        md_len(1'b1, 11, "t5_div_len");
        md_len(1'b0, 6, "t5_mult_len");

        // Reset in the middle of a divide count.
        flush();
        drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        step();
        drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        repeat (4) step();
        chk("t6_busy_pre", 32'(md_busy), 32'd1);
        apply_reset("t6");
        drv(5'd1, 2'd0, 5'd2, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk("t6_after_stall", 32'(last_stall), 32'd0);

        // Random traffic on a small register set, with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            logic ms;
            ms = ($urandom_range(0, 7) == 0);
            drv(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                ms, 1'($urandom_range(0, 1)),
                ms | ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 99) == 0) apply_reset("rnd_rst");
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
